// File: rtl/exp5_detector_jogada_pkg.sv
`default_nettype none
// ============================================================================
// Module : exp5_detector_jogada_pkg
// Brief  : Shared state codes and default sizing for the play detector.
// Rev    : 1.0 - initial release
// ============================================================================
package exp5_detector_jogada_pkg;

  localparam int N_BOTOES_PADRAO        = 4;
  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
  localparam int CW_PADRAO              = 16;

  // Codes are visible on db_estado, so their values are fixed explicitly.
  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    EMITE        = 3'd2,
    REJEITA      = 3'd3,
    PRESSIONADO  = 3'd4,
    FILTRA_SOLTA = 3'd5
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/exp5_detector_jogada_if.sv
`default_nettype none
// ============================================================================
// Module : exp5_detector_jogada_if
// Brief  : Button panel in, play event out, plus debug state code.
// Rev    : 1.0 - initial release
// ============================================================================
interface exp5_detector_jogada_if #(
  parameter int N_BOTOES = 4
);

  logic [N_BOTOES-1:0] botoes;
  logic                jogada;
  logic [N_BOTOES-1:0] jogada_valor;
  logic                multipla;
  logic [2:0]          db_estado;

  // Panel / consumer side: drives buttons, observes events.
  modport master (
    output botoes,
    input  jogada,
    input  jogada_valor,
    input  multipla,
    input  db_estado
  );

  // Detector side.
  modport slave (
    input  botoes,
    output jogada,
    output jogada_valor,
    output multipla,
    output db_estado
  );

endinterface
`default_nettype wire

// File: rtl/exp5_detector_jogada_sincronizador.sv
`default_nettype none
// ============================================================================
// Module : exp5_sincronizador
// Brief  : WIDTH-bit two-flop synchroniser with synchronous reset.
// Rev    : 1.0 - initial release
// ============================================================================
module exp5_sincronizador #(
  parameter int WIDTH = 4
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Two-stage capture of the asynchronous button levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule
`default_nettype wire

// File: rtl/exp5_detector_jogada.sv
`default_nettype none
// ============================================================================
// Module : exp5_detector_jogada
// Brief  : Synchronises and debounces panel buttons; emits one jogada pulse
//          per accepted single-button press, multipla for chorded presses.
// Rev    : 1.0 - initial release
// ============================================================================
module exp5_detector_jogada
  import exp5_detector_jogada_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int CW              = CW_PADRAO
) (
  input wire logic                clock,
  input wire logic                reset,
  exp5_detector_jogada_if.slave   bus
);

  localparam logic [CW-1:0]       c_limite = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0]       c_um_cnt = CW'(1);
  localparam logic [N_BOTOES-1:0] c_um_pad = N_BOTOES'(1);

  estado_t             r_estado;
  estado_t             w_estado_prox;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_prox;
  logic [N_BOTOES-1:0] r_padrao;
  logic [N_BOTOES-1:0] w_padrao_prox;
  logic [N_BOTOES-1:0] r_valor;
  logic [N_BOTOES-1:0] w_valor_prox;
  logic [N_BOTOES-1:0] w_s2;
  logic                w_um_hot;

  exp5_sincronizador #(
    .WIDTH (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (bus.botoes),
    .q     (w_s2)
  );

  // Exactly one bit set in the stored pattern.
  assign w_um_hot = (r_padrao != '0) && ((r_padrao & (r_padrao - c_um_pad)) == '0);

  // State, debounce counter, stored pattern and accepted code registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_cnt    <= '0;
      r_padrao <= '0;
      r_valor  <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
      r_padrao <= w_padrao_prox;
      r_valor  <= w_valor_prox;
    end
  end

  // Next-state and datapath updates; counter is cleared on every FILTRA_* entry
  // and compared before incrementing, so it never wraps.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_padrao_prox = r_padrao;
    w_valor_prox  = r_valor;
    case (r_estado)
      OCIOSO: begin
        if (w_s2 != '0) begin
          w_padrao_prox = w_s2;
          w_cnt_prox    = '0;
          w_estado_prox = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (w_s2 == '0) begin
          w_estado_prox = OCIOSO;
        end else if (w_s2 != r_padrao) begin
          // Pattern changed while bouncing: restart filtering on the new one.
          w_padrao_prox = w_s2;
          w_cnt_prox    = '0;
        end else if (r_cnt == c_limite) begin
          if (w_um_hot) begin
            w_valor_prox  = r_padrao;
            w_estado_prox = EMITE;
          end else begin
            w_estado_prox = REJEITA;
          end
        end else begin
          w_cnt_prox = r_cnt + c_um_cnt;
        end
      end
      EMITE:   w_estado_prox = PRESSIONADO;
      REJEITA: w_estado_prox = PRESSIONADO;
      PRESSIONADO: begin
        // Extra buttons while held are ignored; only a full release matters.
        if (w_s2 == '0) begin
          w_cnt_prox    = '0;
          w_estado_prox = FILTRA_SOLTA;
        end
      end
      FILTRA_SOLTA: begin
        if (w_s2 != '0) begin
          w_estado_prox = PRESSIONADO;
        end else if (r_cnt == c_limite) begin
          w_estado_prox = OCIOSO;
        end else begin
          w_cnt_prox = r_cnt + c_um_cnt;
        end
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  // Moore outputs decoded from the state register.
  assign bus.jogada       = (r_estado == EMITE);
  assign bus.multipla     = (r_estado == REJEITA);
  assign bus.jogada_valor = r_valor;
  assign bus.db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_exp5_detector_jogada.sv
`default_nettype none
// ============================================================================
// Module : tb_exp5_detector_jogada
// Brief  : Self-checking bench for exp5_detector_jogada (DEBOUNCE_CICLOS=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_exp5_detector_jogada;

  localparam int D = 4;
  // Drive at a falling edge -> first pulse seen at the falling edge D+3 later.
  localparam int LAT = D + 3;

  logic clock;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  typedef struct {
    logic       multi;
    logic [3:0] valor;
    int         at;
  } ev_t;

  ev_t sb[$];

  exp5_detector_jogada_if #(.N_BOTOES(4)) bus ();

  exp5_detector_jogada #(
    .N_BOTOES        (4),
    .DEBOUNCE_CICLOS (D),
    .CW              (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the oldest expected event.
  always @(negedge clock) begin
    ev_t e;
    if (bus.jogada && bus.multipla) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_exclusive cyc=%0d jogada=1 multipla=1 required not both", cyc);
    end
    if (bus.jogada || bus.multipla) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected cyc=%0d jogada=%b multipla=%b valor=%b required no pulse",
                 cyc, bus.jogada, bus.multipla, bus.jogada_valor);
      end else begin
        e = sb.pop_front();
        if ({bus.multipla, bus.jogada, bus.jogada_valor} !== {e.multi, ~e.multi, e.valor} || cyc != e.at) begin
          miscompares++;
          $display("FAIL pulse_match cyc=%0d multipla=%b jogada=%b valor=%b required cyc=%0d multipla=%b valor=%b",
                   cyc, bus.multipla, bus.jogada, bus.jogada_valor, e.at, e.multi, e.valor);
        end
      end
    end else if (sb.size() > 0 && sb[0].at <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_missing cyc=%0d required multipla=%b valor=%b at cyc=%0d",
               cyc, sb[0].multi, sb[0].valor, sb[0].at);
      void'(sb.pop_front());
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_event(input logic multi, input logic [3:0] valor);
    ev_t e;
    e.multi = multi;
    e.valor = valor;
    e.at    = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.botoes = 4'b0000;
    wait_cycles(3);
    vectors++;
    if ({bus.jogada, bus.multipla, bus.jogada_valor, bus.db_estado} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_state jogada=%b multipla=%b valor=%b estado=%0d required all 0",
               bus.jogada, bus.multipla, bus.jogada_valor, bus.db_estado);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      vectors++;
      if ({bus.jogada, bus.multipla, bus.jogada_valor, bus.db_estado} !== 9'b0) begin
        miscompares++;
        $display("FAIL idle_state cycle=%0d jogada=%b multipla=%b valor=%b estado=%0d required all 0",
                 i, bus.jogada, bus.multipla, bus.jogada_valor, bus.db_estado);
      end
    end
  endtask

  task automatic test_press_simple();
    bus.botoes = 4'b0100;
    expect_event(1'b0, 4'b0100);
    wait_cycles(30);
    vectors++;
    if (bus.db_estado !== 3'd4) begin
      miscompares++;
      $display("FAIL held_state estado=%0d required 4", bus.db_estado);
    end
    bus.botoes = 4'b0000;
    wait_cycles(LAT - 1);
    vectors++;
    if (bus.db_estado !== 3'd5) begin
      miscompares++;
      $display("FAIL release_filtering estado=%0d required 5", bus.db_estado);
    end
    wait_cycles(1);
    vectors++;
    if (bus.db_estado !== 3'd0 || bus.jogada_valor !== 4'b0100) begin
      miscompares++;
      $display("FAIL release_done estado=%0d valor=%b required 0 and 0100",
               bus.db_estado, bus.jogada_valor);
    end
    wait_cycles(5);
  endtask

  task automatic test_glitch();
    bus.botoes = 4'b0010;
    wait_cycles(2);
    bus.botoes = 4'b0000;
    wait_cycles(2);
    bus.botoes = 4'b0010;
    expect_event(1'b0, 4'b0010);
    wait_cycles(20);
    bus.botoes = 4'b0000;
    wait_cycles(12);
    vectors++;
    if (sb.size() != 0 || bus.jogada_valor !== 4'b0010) begin
      miscompares++;
      $display("FAIL glitch_result pending=%0d valor=%b required 0 and 0010",
               sb.size(), bus.jogada_valor);
    end
  endtask

  task automatic test_multiple();
    bus.botoes = 4'b0011;
    expect_event(1'b1, 4'b0010);
    wait_cycles(20);
    bus.botoes = 4'b0000;
    wait_cycles(12);
    vectors++;
    if (sb.size() != 0 || bus.jogada_valor !== 4'b0010 || bus.db_estado !== 3'd0) begin
      miscompares++;
      $display("FAIL multiple_result pending=%0d valor=%b estado=%0d required 0, 0010, 0",
               sb.size(), bus.jogada_valor, bus.db_estado);
    end
  endtask

  task automatic test_short_release();
    bus.botoes = 4'b1000;
    expect_event(1'b0, 4'b1000);
    wait_cycles(15);
    bus.botoes = 4'b0000;
    wait_cycles(2);
    bus.botoes = 4'b0001;
    wait_cycles(20);
    vectors++;
    if (bus.db_estado !== 3'd4 || bus.jogada_valor !== 4'b1000) begin
      miscompares++;
      $display("FAIL short_release estado=%0d valor=%b required 4 and 1000",
               bus.db_estado, bus.jogada_valor);
    end
    bus.botoes = 4'b0000;
    wait_cycles(10);
    vectors++;
    if (bus.db_estado !== 3'd0) begin
      miscompares++;
      $display("FAIL full_release estado=%0d required 0", bus.db_estado);
    end
    bus.botoes = 4'b0001;
    expect_event(1'b0, 4'b0001);
    wait_cycles(15);
    bus.botoes = 4'b0000;
    wait_cycles(10);
    vectors++;
    if (sb.size() != 0 || bus.jogada_valor !== 4'b0001) begin
      miscompares++;
      $display("FAIL second_press pending=%0d valor=%b required 0 and 0001",
               sb.size(), bus.jogada_valor);
    end
  endtask

  task automatic test_reset_mid_filter();
    bus.botoes = 4'b0100;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(3);
    vectors++;
    if ({bus.jogada, bus.multipla, bus.jogada_valor, bus.db_estado} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_abort jogada=%b multipla=%b valor=%b estado=%0d required all 0",
               bus.jogada, bus.multipla, bus.jogada_valor, bus.db_estado);
    end
    reset = 1'b0;
    expect_event(1'b0, 4'b0100);
    wait_cycles(15);
    bus.botoes = 4'b0000;
    wait_cycles(10);
    vectors++;
    if (sb.size() != 0 || bus.jogada_valor !== 4'b0100 || bus.db_estado !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_repress pending=%0d valor=%b estado=%0d required 0, 0100, 0",
               sb.size(), bus.jogada_valor, bus.db_estado);
    end
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.botoes  = 4'b0000;
    test_reset();
    test_press_simple();
    test_glitch();
    test_multiple();
    test_short_release();
    test_reset_mid_filter();
    wait_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
